// File: rtl/cpu_regfile_dumper.sv
`default_nettype none
// ============================================================================
// Module      : cpu_regfile_dumper
// Description : Bus master for a cpu_register file. It clears every register
//               to a constant, or reads them back in pairs and streams them
//               out over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_regfile_dumper #(
    parameter int              NREG      = 32,
    parameter int              AW        = 5,
    parameter int              DW        = 32,
    parameter logic [DW-1:0]   CLEAR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_req,
    input  logic          dump_req,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] addr1,
    output logic [AW-1:0] addr2,
    output logic [AW-1:0] addrw,
    output logic          writeen,
    output logic [DW-1:0] writeint,
    input  logic [DW-1:0] RD1,
    input  logic [DW-1:0] RD2,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RD     = 3'd2,
        S_SEND_A = 3'd3,
        S_SEND_B = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [AW-1:0] C_ZERO      = '0;
    localparam logic [AW-1:0] C_ONE       = AW'(1);
    localparam logic [AW-1:0] C_TWO       = AW'(2);
    localparam logic [AW-1:0] C_LAST      = AW'(NREG - 1);
    localparam logic [AW-1:0] C_LAST_PAIR = AW'(NREG - 2);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;
    logic [AW-1:0] w_ptr_p1;
    logic [DW-1:0] r_hold_a;
    logic [DW-1:0] r_hold_b;

    // ptr is always even in RD/SEND_B, so ptr+1 never wraps there.
    assign w_ptr_p1 = r_ptr + C_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= C_ZERO;
            r_hold_a <= '0;
            r_hold_b <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (r_state == S_RD) begin
                r_hold_a <= RD1;
                r_hold_b <= RD2;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (init_req) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = C_ZERO;
                end else if (dump_req) begin
                    w_state_nxt = S_RD;
                    w_ptr_nxt   = C_ZERO;
                end
            end
            S_CLEAR: begin
                w_ptr_nxt = w_ptr_p1;
                if (r_ptr == C_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RD: begin
                w_state_nxt = S_SEND_A;
            end
            S_SEND_A: begin
                if (dump_ready) begin
                    w_state_nxt = S_SEND_B;
                end
            end
            S_SEND_B: begin
                if (dump_ready) begin
                    if (r_ptr == C_LAST_PAIR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ptr_nxt   = r_ptr + C_TWO;
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; reset forces IDLE and zeroes them.
    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        addr1      = C_ZERO;
        addr2      = C_ZERO;
        addrw      = C_ZERO;
        writeen    = 1'b0;
        writeint   = '0;
        dump_valid = 1'b0;
        dump_addr  = C_ZERO;
        dump_data  = '0;
        case (r_state)
            S_CLEAR: begin
                writeen  = 1'b1;
                addrw    = r_ptr;
                writeint = CLEAR_VAL;
            end
            S_RD: begin
                addr1 = r_ptr;
                addr2 = w_ptr_p1;
            end
            S_SEND_A: begin
                dump_valid = 1'b1;
                dump_addr  = r_ptr;
                dump_data  = r_hold_a;
            end
            S_SEND_B: begin
                dump_valid = 1'b1;
                dump_addr  = w_ptr_p1;
                dump_data  = r_hold_b;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_regfile_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_regfile_dumper
// Description : Self-checking bench for cpu_regfile_dumper with a model regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_regfile_dumper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_req = 1'b0;
    logic        dump_req = 1'b0;
    logic        busy, done, writeen, dump_valid;
    logic [4:0]  addr1, addr2, addrw, dump_addr;
    logic [31:0] writeint, dump_data, RD1, RD2;
    logic        dump_ready = 1'b0;

    logic        tb_we = 1'b0;
    logic [4:0]  tb_wa = '0;
    logic [31:0] tb_wd = '0;
    logic [31:0] rf [0:31];

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int seq_err = 0;

    always #5 clk = ~clk;

    cpu_regfile_dumper dut (
        .clk(clk), .rst(rst), .init_req(init_req), .dump_req(dump_req),
        .busy(busy), .done(done), .addr1(addr1), .addr2(addr2), .addrw(addrw),
        .writeen(writeen), .writeint(writeint), .RD1(RD1), .RD2(RD2),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data)
    );

    // Model register file: DUT writes take priority over bench preloads.
    always @(posedge clk) begin
        if (writeen)    rf[addrw] <= writeint;
        else if (tb_we) rf[tb_wa] <= tb_wd;
    end
    assign RD1 = rf[addr1];
    assign RD2 = rf[addr2];

    typedef struct {
        logic        ready;
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
    } bp_vec_t;
    bp_vec_t bp_tab [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives ready for the next edge and logs the transfer that edge will make.
    task automatic drive_ready(input logic r);
        dump_ready = r;
        if (dump_valid && r) begin
            if (dump_addr != 5'(xfer_cnt)) seq_err++;
            xfer_cnt++;
        end
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'hA500_0000 + 32'(k);
    endfunction

    // mode 0: pattern, 1: all cleared, 2: regs 0..9 cleared and rest pattern
    function automatic logic [31:0] exp_word(input int mode, input int k);
        if (mode == 1) return 32'h0;
        if (mode == 2 && k < 10) return 32'h0;
        return pat(k);
    endfunction

    task automatic preload();
        for (int k = 0; k < 32; k++) begin
            tb_we = 1'b1;
            tb_wa = 5'(k);
            tb_wd = pat(k);
            step();
        end
        tb_we = 1'b0;
    endtask

    task automatic do_dump(input int mode);
        int nw;
        nw = 0;
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        step();
        dump_req = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            step();
            if (c == 1) check("first_valid", 64'(dump_valid), 64'd1);
            if (c < 48) begin
                if (dump_valid) begin
                    check("dump_addr", 64'(dump_addr), 64'(nw));
                    check("dump_data", 64'(dump_data), 64'(exp_word(mode, nw)));
                    nw++;
                end
            end else begin
                check("dump_done", 64'(done), 64'd1);
                check("dump_busy_at_done", 64'(busy), 64'd1);
            end
        end
        check("dump_words", 64'(nw), 64'd32);
        step();
        check("dump_busy_after", 64'({busy, done}), 64'd0);
    endtask

    initial begin
        bp_tab[0] = '{1'b0, 1'b0, 5'd0, 32'h0};
        for (int i = 1; i <= 4; i++) bp_tab[i] = '{1'b0, 1'b1, 5'd6, 32'hA500_0006};
        bp_tab[5] = '{1'b1, 1'b1, 5'd6, 32'hA500_0006};
        bp_tab[6] = '{1'b1, 1'b1, 5'd7, 32'hA500_0007};
        bp_tab[7] = '{1'b1, 1'b0, 5'd0, 32'h0};
        bp_tab[8] = '{1'b1, 1'b1, 5'd8, 32'hA500_0008};

        // Reset state
        #2;
        check("reset_ctrl", 64'({busy, done, writeen, dump_valid, addrw, addr1, addr2, dump_addr}), 64'd0);
        check("reset_data", {writeint, dump_data}, 64'd0);
        step();
        rst = 1'b0;

        // Pattern readback
        preload();
        do_dump(0);

        // Backpressure on pair (6,7)
        xfer_cnt = 0;
        seq_err  = 0;
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        step();
        dump_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            drive_ready(1'b1);
        end
        for (int i = 0; i < 9; i++) begin
            step();
            check("bp_valid", 64'(dump_valid), 64'(bp_tab[i].valid));
            check("bp_addr", 64'(dump_addr), 64'(bp_tab[i].addr));
            check("bp_data", 64'(dump_data), 64'(bp_tab[i].data));
            drive_ready(bp_tab[i].ready);
        end
        for (int c = 0; c < 60; c++) begin
            step();
            if (done) break;
            drive_ready(1'b1);
        end
        check("bp_done", 64'(done), 64'd1);
        check("bp_xfer_count", 64'(xfer_cnt), 64'd32);
        check("bp_xfer_order", 64'(seq_err), 64'd0);
        step();

        // Priority (init wins), dump_req ignored during CLEAR
        init_req = 1'b1;
        dump_req = 1'b1;
        step();
        init_req = 1'b0;
        dump_req = 1'b0;
        for (int c = 0; c < 32; c++) begin
            if (c > 0) step();
            check("clr_we", 64'(writeen), 64'd1);
            check("clr_addrw", 64'(addrw), 64'(c));
            check("clr_data", 64'(writeint), 64'd0);
            dump_req = (c == 5);
        end
        step();
        check("clr_done", 64'({done, writeen}), 64'b10);
        for (int c = 0; c < 3; c++) begin
            step();
            check("clr_no_dump", 64'({busy, dump_valid}), 64'd0);
        end

        // Clear then dump: all zero
        do_dump(1);

        // Async reset mid-clear at ptr 10
        preload();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int c = 1; c <= 10; c++) step();
        check("rst_clr_ptr", 64'(addrw), 64'd10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_clr_outs", 64'({writeen, busy, addrw}), 64'd0);
        step();
        rst = 1'b0;
        do_dump(2);

        // Async reset in SEND_B
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        step();
        dump_req = 1'b0;
        step();
        step();
        check("rst_sb_pre", 64'({dump_valid, dump_addr}), 64'({1'b1, 5'd1}));
        dump_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_sb_valid", 64'({dump_valid, busy}), 64'd0);
        step();
        rst = 1'b0;
        do_dump(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
